// File: rtl/multisim_push_arbiter_pkg.sv
// Shared types and helpers for the multisim push arbiter.
package multisim_push_arb_pkg;

  localparam int unsigned MAX_REQ = 16;

  typedef logic [3:0] arb_idx_t;

  // Round-robin successor of ptr among n requesters.
  function automatic arb_idx_t rr_next(arb_idx_t ptr, int unsigned n);
    if ({28'b0, ptr} + 32'd1 >= n) begin
      return '0;
    end
    return ptr + arb_idx_t'(1);
  endfunction

endpackage

// File: rtl/multisim_push_arbiter_if.sv
// Requester-side and push-server-side handshake bundle for multisim_push_arbiter.
// Output width grows by the index tag when MULTISIM_PUSH_ARB_TAG_EN is defined.
interface multisim_push_arbiter_if #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned IDX_W = $clog2(N_REQ);
`ifdef MULTISIM_PUSH_ARB_TAG_EN
  localparam int unsigned OUT_W = DATA_WIDTH + IDX_W;
`else
  localparam int unsigned OUT_W = DATA_WIDTH;
`endif

  logic [N_REQ-1:0]                 req_vld;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]                 req_rdy;
  logic                             out_vld;
  logic [OUT_W-1:0]                 out_data;
  logic                             out_rdy;
  logic [IDX_W-1:0]                 grant_idx;

  // Producers and push server side
  modport master (
    output req_vld, req_data, out_rdy,
    input  req_rdy, out_vld, out_data, grant_idx
  );

  // Arbiter side
  modport slave (
    input  req_vld, req_data, out_rdy,
    output req_rdy, out_vld, out_data, grant_idx
  );

endinterface

// File: rtl/multisim_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Uses a doubled request vector so the wrap becomes a plain lowest-bit search.
module multisim_rr_pick
  import multisim_push_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt_onehot,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_any
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_masked;
  int             w_pos;

  assign w_dbl = {i_req, i_req};
  assign o_any = |i_req;

  // Drop doubled bits below the pointer; the upper copy covers the wrap.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < int'(2 * N); i++) begin
      w_masked[i] = w_dbl[i] & (i >= int'(i_ptr));
    end
  end

  // Lowest surviving bit position.
  always_comb begin
    w_pos = 0;
    for (int i = int'(2 * N) - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_pos = i;
      end
    end
  end

  // Fold the doubled position back to a requester index and one-hot grant.
  always_comb begin
    o_gnt_idx    = (w_pos >= int'(N)) ? IDX_W'(w_pos - int'(N)) : IDX_W'(w_pos);
    o_gnt_onehot = '0;
    for (int i = 0; i < int'(N); i++) begin
      o_gnt_onehot[i] = o_any & (o_gnt_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/multisim_push_arbiter.sv
// Round-robin arbiter sharing one push-server channel among N_REQ requesters,
// with a single registered output stage.
// Optional: MULTISIM_PUSH_ARB_TAG_EN prepends the winner index to out_data.
module multisim_push_arbiter
  import multisim_push_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic                    clk,
  input logic                    rst,
  multisim_push_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
`ifdef MULTISIM_PUSH_ARB_TAG_EN
  localparam int unsigned OUT_W = DATA_WIDTH + IDX_W;
`else
  localparam int unsigned OUT_W = DATA_WIDTH;
`endif

  logic             r_out_vld;
  logic [OUT_W-1:0] r_out_data;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_rr_ptr;

  logic             w_load;
  logic             w_fire;
  logic             w_any;
  logic [N_REQ-1:0] w_onehot;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [OUT_W-1:0] w_beat;

  multisim_rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .i_req        (bus.req_vld),
    .i_ptr        (r_rr_ptr),
    .o_gnt_onehot (w_onehot),
    .o_gnt_idx    (w_gnt_idx),
    .o_any        (w_any)
  );

  // Output register may take a beat when empty or draining this cycle.
  assign w_load      = ~r_out_vld | bus.out_rdy;
  assign w_fire      = w_load & w_any & ~rst;
  assign bus.req_rdy = w_fire ? w_onehot : '0;

`ifdef MULTISIM_PUSH_ARB_TAG_EN
  assign w_beat = {w_gnt_idx, bus.req_data[w_gnt_idx]};
`else
  assign w_beat = bus.req_data[w_gnt_idx];
`endif

  // Output stage and round-robin pointer; pointer moves only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else if (w_fire) begin
      r_out_vld   <= 1'b1;
      r_out_data  <= w_beat;
      r_grant_idx <= w_gnt_idx;
      r_rr_ptr    <= IDX_W'(rr_next(arb_idx_t'(w_gnt_idx), N_REQ));
    end else if (bus.out_rdy) begin
      r_out_vld <= 1'b0;
    end
  end

  assign bus.out_vld   = r_out_vld;
  assign bus.out_data  = r_out_data;
  assign bus.grant_idx = r_grant_idx;

  // Legal requester count.
  a_n_req_range: assert property (@(posedge clk) (N_REQ >= 2) && (N_REQ <= MAX_REQ));

  // At most one requester is granted per cycle.
  a_rdy_onehot: assert property (@(posedge clk) $onehot0(bus.req_rdy));

  // Requesters must hold valid and payload until accepted.
  for (genvar g = 0; g < N_REQ; g++) begin : g_hold_chk
    a_no_retract: assert property (@(posedge clk) disable iff (rst)
      bus.req_vld[g] && !bus.req_rdy[g] |=> bus.req_vld[g] && $stable(bus.req_data[g]));
  end

endmodule

// File: tb/tb_multisim_push_arbiter.sv
// Randomized and directed bench for multisim_push_arbiter against a behavioural model.
module tb_multisim_push_arbiter;

  localparam int unsigned NReq  = 4;
  localparam int unsigned DataW = 64;
  localparam int unsigned IdxW  = 2;
`ifdef MULTISIM_PUSH_ARB_TAG_EN
  localparam int unsigned OutW = DataW + IdxW;
`else
  localparam int unsigned OutW = DataW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multisim_push_arbiter_if #(.N_REQ(NReq), .DATA_WIDTH(DataW)) bus ();

  multisim_push_arbiter #(
    .N_REQ      (NReq),
    .DATA_WIDTH (DataW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Requester model: pending flag and held payload per requester.
  logic             pend  [NReq];
  logic [DataW-1:0] pdata [NReq];
  logic             rdy_in;

  // Reference output state.
  logic            m_vld;
  logic [OutW-1:0] m_data;
  int              m_gidx;
  int              m_ptr;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OutW-1:0] mk_beat(int w, logic [DataW-1:0] d);
`ifdef MULTISIM_PUSH_ARB_TAG_EN
    return {IdxW'(w), d};
`else
    if (w < 0) return '0;
    return d;
`endif
  endfunction

  task automatic drive();
    for (int i = 0; i < int'(NReq); i++) begin
      bus.req_vld[i]  = pend[i];
      bus.req_data[i] = pdata[i];
    end
    bus.out_rdy = rdy_in;
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_gidx = 0;
    m_ptr  = 0;
  endtask

  // One clock: check DUT against model at negedge, then advance the model at posedge.
  task automatic cycle();
    int w;
    logic [127:0] exp_rdy;
    drive();
    @(negedge clk);
    w = -1;
    if (!rst && (!m_vld || rdy_in)) begin
      for (int k = 0; k < int'(NReq); k++) begin
        int j;
        j = (m_ptr + k) % int'(NReq);
        if (pend[j] && w < 0) w = j;
      end
    end
    exp_rdy = (w < 0) ? 128'd0 : (128'd1 << w);
    check_eq("req_rdy", 128'(bus.req_rdy), exp_rdy);
    check_eq("out_vld", 128'(bus.out_vld), 128'(m_vld));
    check_eq("out_data", 128'(bus.out_data), 128'(m_data));
    check_eq("grant_idx", 128'(bus.grant_idx), 128'(m_gidx));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (w >= 0) begin
      m_vld   = 1'b1;
      m_data  = mk_beat(w, pdata[w]);
      m_gidx  = w;
      m_ptr   = (w + 1) % int'(NReq);
      pend[w] = 1'b0;
    end else if (rdy_in) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic [DataW-1:0] d);
    pend[i]  = 1'b1;
    pdata[i] = d;
  endtask

  initial begin
    logic [DataW-1:0] exp64;
    for (int i = 0; i < int'(NReq); i++) begin
      pend[i]  = 1'b1;
      pdata[i] = DataW'(64'hA0 + 64'(i));
    end
    rdy_in = 1'b1;
    drive();
    @(posedge clk);
    #1;
    model_reset();

    // Reset held with every requester valid: no grants, output empty.
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;

    // Fairness: all valid, continuously refilled.
    for (int k = 0; k < 5; k++) begin
      cycle();
      exp64 = 64'hA0 + 64'(k % 4);
      check_eq("fair_data", 128'(bus.out_data[DataW-1:0]), 128'(exp64));
      for (int i = 0; i < int'(NReq); i++) begin
        if (!pend[i]) set_req(i, DataW'(64'hA0 + 64'(i)));
      end
    end
    // Drain the remaining pending requests 1,2,3 without refill.
    pend[0] = 1'b0;
    repeat (3) cycle();
    check_eq("drain_idx", 128'(bus.grant_idx), 128'd3);

    // Backpressure with req 2 pending.
    rdy_in = 1'b0;
    set_req(2, 64'h222);
    repeat (5) cycle();
    check_eq("bp_hold_data", 128'(bus.out_data[DataW-1:0]), 128'hA3);
    check_eq("bp_hold_rdy", 128'(bus.req_rdy), 128'd0);
    rdy_in = 1'b1;
    cycle();
    check_eq("bp_release_idx", 128'(bus.grant_idx), 128'd2);
    cycle();
    check_eq("drain_vld", 128'(bus.out_vld), 128'd0);
    check_eq("drain_keep", 128'(bus.out_data[DataW-1:0]), 128'h222);

    // Sparse: lone req 3, then req 1 wins over req 3 from pointer 0.
    set_req(3, 64'hDEAD_BEEF);
    cycle();
    check_eq("sparse_data", 128'(bus.out_data[DataW-1:0]), 128'hDEAD_BEEF);
    check_eq("sparse_vld", 128'(bus.out_vld), 128'd1);
    set_req(1, 64'h111);
    set_req(3, 64'h333);
    cycle();
    check_eq("sparse_first", 128'(bus.grant_idx), 128'd1);
    cycle();
    check_eq("sparse_second", 128'(bus.grant_idx), 128'd3);

    // Reset while a beat is held and req 2 waits.
    set_req(1, 64'h11);
    cycle();
    rdy_in = 1'b0;
    set_req(2, 64'h22);
    cycle();
    rst = 1'b1;
    cycle();
    check_eq("rst_mid_vld", 128'(bus.out_vld), 128'd0);
    rst = 1'b0;
    rdy_in = 1'b1;
    cycle();
    check_eq("rst_regrant_idx", 128'(bus.grant_idx), 128'd2);
    check_eq("rst_regrant_data", 128'(bus.out_data[DataW-1:0]), 128'h22);

`ifdef MULTISIM_PUSH_ARB_TAG_EN
    set_req(1, 64'h5);
    cycle();
    check_eq("tag_beat", 128'(bus.out_data), {62'd0, 2'b01, 64'h5});
`endif
    cycle();

    // Random traffic, backpressure and occasional reset.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < int'(NReq); i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) set_req(i, {$urandom, $urandom});
      end
      rdy_in = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
